// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Consumed by rr_arbiter and uart_tx_arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_START,
        WAIT_DONE
    } arb_state_t;

    localparam logic [3:0] HDR_TAG        = 4'hA;
    localparam int         DEFAULT_DATA_W = 8;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after
// last_grant+1, wrapping modulo N_REQ.
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]  last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             any_valid
);

    // NOTE: every variable written here gets a default before the loop, so no latch is inferred.
    always_comb begin
        logic [ID_W:0] sum;
        logic          found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            sum = {1'b0, last_grant} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
            if (!found && req_valid[sum[ID_W-1:0]]) begin
                found                  = 1'b1;
                grant[sum[ID_W-1:0]]   = 1'b1;
                grant_idx              = sum[ID_W-1:0];
            end
        end
    end

    assign any_valid = |req_valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among N_REQ byte producers,
// with a start watchdog. Define UART_ARB_HEADER_EN to prefix each byte with a header frame.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int DATA_W        = DEFAULT_DATA_W,
    parameter int START_TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_W-1:0]     req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        tx_enable,
    input  logic                        tx_ready,
    output logic [id_width(N_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic                        timeout_err
);

    localparam int ID_W  = id_width(N_REQ);
    localparam int CNT_W = id_width(START_TIMEOUT);

    arb_state_t       state, state_next;
    logic [ID_W-1:0]  last_grant;
    logic [CNT_W-1:0] wd_cnt;
    logic [N_REQ-1:0] pick;
    logic [ID_W-1:0]  pick_idx;
    logic             any_valid;
    logic             take;
    logic             wd_expired;
    logic             more_frames;

`ifdef UART_ARB_HEADER_EN
    logic              phase;
    logic [DATA_W-1:0] data_hold;
    logic [7:0]        hdr_byte;

    assign hdr_byte    = {HDR_TAG, 4'(pick_idx)};
    assign more_frames = !phase;
`else
    assign more_frames = 1'b0;
`endif

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .grant      (pick),
        .grant_idx  (pick_idx),
        .any_valid  (any_valid)
    );

    assign take       = (state == IDLE) && tx_ready && any_valid;
    assign wd_expired = (state == WAIT_START) && tx_ready &&
                        (wd_cnt == CNT_W'(START_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:       if (take) state_next = SEND;
            SEND:       state_next = WAIT_START;
            WAIT_START: begin
                if (!tx_ready)       state_next = WAIT_DONE;
                else if (wd_expired) state_next = IDLE;
            end
            WAIT_DONE:  if (tx_ready) state_next = more_frames ? SEND : IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant <= ID_W'(N_REQ - 1);
            grant_id   <= '0;
            tx_data    <= '0;
            wd_cnt     <= '0;
`ifdef UART_ARB_HEADER_EN
            phase      <= 1'b0;
            data_hold  <= '0;
`endif
        end else begin
            if (take) begin
                last_grant <= pick_idx;
                grant_id   <= pick_idx;
`ifdef UART_ARB_HEADER_EN
                tx_data    <= DATA_W'(hdr_byte);
                data_hold  <= req_data[pick_idx*DATA_W +: DATA_W];
                phase      <= 1'b0;
`else
                tx_data    <= req_data[pick_idx*DATA_W +: DATA_W];
`endif
            end
            if (state == SEND)
                wd_cnt <= '0;
            else if ((state == WAIT_START) && tx_ready && !wd_expired)
                wd_cnt <= wd_cnt + 1'b1;
`ifdef UART_ARB_HEADER_EN
            // Header frame finished: swap the held byte in for the data frame.
            if ((state == WAIT_DONE) && tx_ready && !phase) begin
                phase   <= 1'b1;
                tx_data <= data_hold;
            end
`endif
        end
    end

    // NOTE: outputs are gated by reset so nothing escapes before the state register has reset.
    always_comb begin
        req_ready   = '0;
        tx_enable   = 1'b0;
        busy        = 1'b0;
        timeout_err = 1'b0;
        if (reset) begin
            if (take) req_ready = pick;
            tx_enable   = (state == SEND);
            busy        = (state != IDLE);
            timeout_err = wd_expired;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: reference round-robin model, queue of
// expected UART bytes, and a UART model with random frame lengths.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int N_REQ         = 4;
    localparam int DATA_W        = 8;
    localparam int START_TIMEOUT = 16;
    localparam int ID_W          = 2;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic [N_REQ-1:0]        req_valid = '0;
    logic [N_REQ*DATA_W-1:0] req_data = '0;
    logic [N_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]       tx_data;
    logic                    tx_enable;
    logic                    tx_ready = 1'b1;
    logic [ID_W-1:0]         grant_id;
    logic                    busy;
    logic                    timeout_err;

    uart_tx_arbiter #(
        .N_REQ         (N_REQ),
        .DATA_W        (DATA_W),
        .START_TIMEOUT (START_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_enable   (tx_enable),
        .tx_ready    (tx_ready),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference arbitration: first valid index after the previous winner, wrapping.
    function automatic int rr_pick(input logic [N_REQ-1:0] v, input int last);
        for (int k = 1; k <= N_REQ; k++) begin
            if (v[(last + k) % N_REQ]) return (last + k) % N_REQ;
        end
        return -1;
    endfunction

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] sent_log[$];
    int               model_last = N_REQ - 1;
    int               accepts = 0, frames = 0, timeouts = 0, last_accept_idx = -1;
    logic [N_REQ-1:0] acc_mask = '0, prev_rr = '0;
    bit               in_flight = 0, seen_low = 0, prev_txen = 0;
    int               to_expect = 0, stall = 0;
    bit               uart_dead = 0;
    int               frame_len = 10;

    function automatic logic [DATA_W-1:0] log_at(input int i);
        return (sent_log.size() > i) ? sent_log[i] : 'x;
    endfunction

    // UART model: after a start strobe, fall within 0..2 cycles and stay low frame_len cycles.
    int u_wait = 0, u_low = 0;
    bit u_arm = 0;
    always @(posedge clk) begin
        #2;
        if (!reset) begin
            tx_ready = 1'b1; u_arm = 0; u_low = 0;
        end else if (u_low > 0) begin
            u_low--;
            if (u_low == 0) tx_ready = 1'b1;
        end else if (u_arm) begin
            if (u_wait == 0) begin tx_ready = 1'b0; u_low = frame_len; u_arm = 0; end
            else u_wait--;
        end else if (tx_enable && !uart_dead) begin
            u_arm = 1; u_wait = $urandom_range(0, 2);
        end
    end

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin : mon
        int w;
        if (!reset) begin
            exp_q.delete();
            model_last = N_REQ - 1;
            in_flight = 0; seen_low = 0; to_expect = 0; prev_txen = 0;
            acc_mask = '0; prev_rr = '0; stall = 0;
        end else begin
            acc_mask = req_ready;
            if (to_expect > 0) begin
                to_expect--;
                if (to_expect == 0) begin
                    check("timeout_pulse", timeout_err, 1'b1);
                    timeouts++;
                    exp_q.delete();
                    in_flight = 0;
                end else if (timeout_err) check("timeout_early", timeout_err, 1'b0);
            end else if (timeout_err) check("timeout_unexpected", timeout_err, 1'b0);

            if (tx_enable) begin
                check("tx_enable_width", prev_txen, 1'b0);
                if (exp_q.size() == 0) check("tx_enable_unexpected", tx_enable, 1'b0);
                else begin
                    check("tx_data", tx_data, exp_q.pop_front());
                    sent_log.push_back(tx_data);
                end
                check("grant_id", grant_id, model_last);
                frames++;
                in_flight = 1; seen_low = 0;
                if (uart_dead) to_expect = START_TIMEOUT;
            end
            prev_txen = tx_enable;

            if (in_flight && !tx_enable) begin
                if (!tx_ready) seen_low = 1;
                else if (seen_low) begin
                    check("req_ready_before_idle", req_ready, '0);
                    in_flight = 0;
                end
            end

            if (req_ready != '0) begin
                check("req_ready_width", prev_rr, '0);
                check("req_ready_when_busy", (in_flight || exp_q.size() != 0), 1'b0);
                check("req_ready_tx_ready", tx_ready, 1'b1);
                w = rr_pick(req_valid, model_last);
                if (w < 0) check("req_ready_no_valid", req_ready, '0);
                else begin
                    check("req_ready_onehot", req_ready, 32'(1) << w);
`ifdef UART_ARB_HEADER_EN
                    exp_q.push_back({4'hA, 4'(w)});
`endif
                    exp_q.push_back(req_data[w*DATA_W +: DATA_W]);
                    model_last = w; last_accept_idx = w; accepts++;
                end
            end
            prev_rr = req_ready;

            if (!in_flight && exp_q.size() == 0 && to_expect == 0 && tx_ready &&
                req_valid != '0 && req_ready == '0) stall++;
            else stall = 0;
            if (stall >= 2) begin
                check("grant_stall_cycles", stall, 1);
                stall = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        repeat (cycles) tick();
        reset = 1'b1;
    endtask

    task automatic wait_accepts(input int target, input int budget);
        int n = 0;
        while (accepts < target && n < budget) begin tick(); n++; end
        check("wait_accepts", (accepts >= target), 1'b1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin tick(); n++; end
        check("wait_idle", busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, n;
        // Reset with every requester valid.
        req_valid = '1;
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        reset = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        check("rst_req_ready", req_ready, '0);
        check("rst_tx_enable", tx_enable, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        check("rst_tx_data", tx_data, '0);
        check("rst_grant_id", grant_id, '0);
        frames = 0; sent_log.delete();
        tick();
        reset = 1'b1;
        wait_accepts(1, 20);
        req_valid = '0;
        wait_idle(100);
        check("first_grant_idx", last_accept_idx, 0);
`ifndef UART_ARB_HEADER_EN
        check("first_frames", frames, 1);
        check("first_byte", log_at(0), 8'h11);
`endif

        // Requesters 0, 1, 3 continuously valid.
        do_reset(3);
        frame_len = 10; sent_log.delete();
        base = accepts;
        req_valid = 4'b1011;
        wait_accepts(base + 4, 400);
        req_valid = '0;
        wait_idle(200);
`ifndef UART_ARB_HEADER_EN
        check("rr_count", sent_log.size(), 4);
        check("rr_byte0", log_at(0), 8'h11);
        check("rr_byte1", log_at(1), 8'h22);
        check("rr_byte2", log_at(2), 8'h44);
        check("rr_byte3", log_at(3), 8'h11);
`endif

        // UART never acknowledges: watchdog, then requester 2 regranted.
        do_reset(3);
        uart_dead = 1; timeouts = 0; sent_log.delete();
        req_data[2*DATA_W +: DATA_W] = 8'h5A;
        base = accepts;
        req_valid = 4'b0100;
        wait_accepts(base + 2, 200);
        req_valid = '0;
        wait_idle(100);
        uart_dead = 0;
        check("wd_timeouts", timeouts, 2);
        check("wd_regrant_idx", last_accept_idx, 2);
`ifndef UART_ARB_HEADER_EN
        check("wd_byte", log_at(1), 8'h5A);
`endif

        // Request raised during WAIT_DONE.
        frame_len = 8;
        req_data[1*DATA_W +: DATA_W] = 8'h77;
        req_data[3*DATA_W +: DATA_W] = 8'h99;
        base = accepts;
        req_valid = 4'b0010;
        wait_accepts(base + 1, 50);
        req_valid = '0;
        n = 0;
        while (tx_ready && n < 20) begin tick(); n++; end
        tick();
        check("wd_phase_busy", busy, 1'b1);
        req_valid = 4'b1000;
        wait_accepts(base + 2, 100);
        req_valid = '0;
        wait_idle(100);
        check("done_next_idx", last_accept_idx, 3);

        // Reset during WAIT_DONE restores last_grant.
        base = accepts;
        req_valid = 4'b0100;
        wait_accepts(base + 1, 50);
        req_valid = '0;
        n = 0;
        while (tx_ready && n < 20) begin tick(); n++; end
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_tx_enable", tx_enable, 1'b0);
        tick(); tick();
        base = accepts;
        req_valid = '1;
        reset = 1'b1;
        wait_accepts(base + 1, 20);
        req_valid = '0;
        wait_idle(100);
        check("post_rst_idx", last_accept_idx, 0);

`ifdef UART_ARB_HEADER_EN
        // Header frame precedes the data frame, one acceptance per grant.
        do_reset(3);
        sent_log.delete(); frames = 0;
        req_data[3*DATA_W +: DATA_W] = 8'hC3;
        base = accepts;
        req_valid = 4'b1000;
        wait_accepts(base + 1, 20);
        req_valid = '0;
        wait_idle(200);
        check("hdr_accepts", accepts - base, 1);
        check("hdr_frames", frames, 2);
        check("hdr_byte0", log_at(0), 8'hA3);
        check("hdr_byte1", log_at(1), 8'hC3);
`endif

        // Randomized traffic against the scoreboard.
        do_reset(3);
        base = accepts;
        for (int c = 0; c < 3000; c++) begin
            frame_len = $urandom_range(1, 12);
            for (int i = 0; i < N_REQ; i++) begin
                if (acc_mask[i]) req_valid[i] = 1'b0;
                else if (req_valid[i]) begin
                    if ($urandom_range(0, 31) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req_data[i*DATA_W +: DATA_W] = 8'($urandom);
                    req_valid[i] = 1'b1;
                end
            end
            tick();
        end
        req_valid = '0;
        wait_idle(200);
        check("random_progress", (accepts - base > 50), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares the single `basic_uart` transmitter among `N_REQ` byte producers, such as MLP output stages and debug taps. It accepts one byte per valid/ready transfer and drives the UART `tx_data`/`tx_enable` pins. It then tracks `tx_ready` through start and completion before granting the next requester. A watchdog recovers if the UART never acknowledges a start.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..16.
- `DATA_W`, default 8: byte width. Must equal the UART data width.
- `START_TIMEOUT`, default 16: cycles allowed for `tx_ready` to fall after `tx_enable`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-low.
- `req_valid` in `N_REQ`: bit i set means requester i holds a byte.
- `req_data` in `N_REQ*DATA_W`: requester i's byte at bits `[i*DATA_W +: DATA_W]`.
- `req_ready` out `N_REQ`: one-hot acceptance strobe.
- `tx_data` out `DATA_W`: byte to the UART.
- `tx_enable` out 1: one-cycle start strobe to the UART.
- `tx_ready` in 1: UART idle flag. High means idle; low means shifting.
- `grant_id` out `$clog2(N_REQ)`: index of the requester currently being served.
- `busy` out 1: high in any state other than IDLE.
- `timeout_err` out 1: one-cycle pulse when the watchdog fires.

## Operation
State machine states: IDLE, SEND, WAIT_START, WAIT_DONE.

- **IDLE**
  - A transfer occurs when `tx_ready`=1 and at least one `req_valid` bit is set.
  - The round-robin pick is the first set bit at or after `last_grant+1`, modulo `N_REQ`.
  - `req_ready` is combinational and one-hot on the winner during that cycle only.
  - At that edge the block latches `req_data` of the winner into `tx_data`, sets `grant_id` and `last_grant` to the winner, and moves to SEND.
- **SEND**
  - `tx_enable`=1 for exactly this cycle.
  - Clears the watchdog counter and moves to WAIT_START.
- **WAIT_START**
  - `tx_ready`=0: move to WAIT_DONE.
  - Otherwise the counter increments.
  - When the counter reaches `START_TIMEOUT-1`: pulse `timeout_err` and return to IDLE. The byte is dropped and `last_grant` still advances.
- **WAIT_DONE**
  - `tx_ready`=1: return to IDLE.
  - No timeout in this state.

General rules:
- `tx_data` is held stable from SEND until the next transfer.
- Requesters must hold `req_valid` and data stable until they see `req_ready`. Deasserting `req_valid` early is legal; that requester is simply not served.
- `req_valid` changes outside IDLE are ignored.
- Reset values: state IDLE, `last_grant`=`N_REQ-1` (requester 0 wins first), and `tx_data`, `grant_id`, counter all 0.
- Outputs in reset: `req_ready`, `tx_enable`, `busy` and `timeout_err` are all 0.
- Reset in any state aborts immediately. No `tx_enable` is issued during or in the cycle after reset.

## Timing
- Transfer at edge k. `tx_enable` and the new `tx_data` are visible in cycle k+1.
- Earliest next transfer is 2 cycles after `tx_ready` returns high in WAIT_DONE: one cycle to reach IDLE, then the grant cycle.
- A single requester with `req_valid` held high gets one byte per UART frame plus 3 cycles.
- `tx_ready` rising in the same cycle as SEND is ignored; only WAIT_START samples it.

## Configuration
- Macro `UART_ARB_HEADER_EN`.
- **Defined:** each grant sends two UART frames.
  - First frame is the header byte `{4'hA, grant_id zero-extended to 4 bits}`, then the latched data byte.
  - A phase bit selects which byte is on `tx_data`. The SEND / WAIT_START / WAIT_DONE cycle runs twice.
  - WAIT_DONE of the header phase goes directly to SEND for the data phase, without passing through IDLE.
  - A watchdog timeout in either phase drops the whole grant.
- **Undefined:** one frame per grant, exactly as in Operation. The phase bit is absent.

## Structure
- Package `uart_arb_pkg` holds:
  - the state enum;
  - the `HDR_TAG`=4'hA constant;
  - the `DATA_W` default;
  - the function that computes `grant_id` width.
- Sub-module `rr_arbiter`:
  - combinational round-robin pick from (`req_valid`, `last_grant`);
  - outputs a one-hot grant, encoded index and `any_valid`.
  - The FSM, data latch and watchdog live in `uart_tx_arbiter`.

## Test plan
- Reset held low 5 cycles with all `req_valid` set → all outputs 0. After release, requester 0 is granted first, with `tx_data` equal to `req_data[0]` and `tx_enable` pulsed exactly once.
- Requesters 0, 1 and 3 continuously valid (data 0x11, 0x22, 0x44) with a UART model that drops `tx_ready` for 10 cycles per frame → byte order 0x11, 0x22, 0x44, 0x11. Every `req_ready` is one-hot and 1 cycle wide.
- Only requester 2 valid with data 0x5A and `tx_ready` never falls → `timeout_err` pulses 16 cycles after the `tx_enable` cycle, state returns to IDLE, and requester 2 is regranted next.
- `req_valid` asserted while in WAIT_DONE → no `req_ready` until 1 cycle after `tx_ready` rises.
- Reset driven low during WAIT_DONE → `busy`=0 and `tx_enable`=0 in the next cycle, and `last_grant` returns to `N_REQ-1`.
- With `UART_ARB_HEADER_EN` defined, requester 3 valid with data 0xC3 → frames 0xA3 then 0xC3 with two `tx_enable` pulses, and only one `req_ready` pulse.
